// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, prefetch entry
// layout and the NOP encoding used for bubbles.
package fetch_pkg;

   localparam logic [31:0] NOP_INSN = 32'h0;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] addr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus: req/gnt address phase followed by
// in-order rvalid/rdata responses.
interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {ins, addr} entries with a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   // A push into a full FIFO is only accepted when a pop frees the slot.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, prefetch buffering, branch redirect/flush and the insi/diri output
// register. Define FETCH_PERF_EN to add the perf_fetched/perf_bubbles counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] PC_STEP    = 32'd4,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   fetch_if.master     imem,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] insi,
   output logic [31:0] diri,
   output logic        valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             valid_q, valid_d;
   logic [31:0]      ins_q, ins_d;
   logic [31:0]      dir_q, dir_d;

   logic             fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head, fifo_wdata;

   logic credit_ok, req, granted, rsp_drop, rsp_take, rsp_any, load;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (fifo_clear),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Buffered plus in-flight words never exceed the FIFO, so every accepted
   // response is guaranteed a slot.
   assign credit_ok = !fifo_full &&
                      (({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_W);
   assign req       = (state_q == FETCH) && credit_ok;
   assign granted   = req && imem.imem_gnt;
   assign rsp_drop  = imem.imem_rvalid && (drop_q != '0);
   assign rsp_take  = imem.imem_rvalid && (drop_q == '0) && (outst_q != '0);
   assign rsp_any   = rsp_drop || rsp_take;
   assign load      = !valid_q || !stall;

   assign fifo_wdata.ins  = imem.imem_rdata;
   assign fifo_wdata.addr = resp_pc_q;

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;
   assign insi           = ins_q;
   assign diri           = dir_q;
   assign valid          = valid_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      valid_d    = valid_q;
      ins_d      = ins_q;
      dir_d      = dir_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;

      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = FETCH;
         FLUSH:   if (drop_q == '0) state_d = FETCH;
         default: state_d = IDLE;
      endcase

      if (granted)  pc_d = pc_q + PC_STEP;
      if (rsp_take) resp_pc_d = resp_pc_q + PC_STEP;
      outst_d = outst_q + CNT_W'(granted) - CNT_W'(rsp_take);
      drop_d  = drop_q - CNT_W'(rsp_drop);

      // A word arriving while the FIFO is empty bypasses it so the pipeline
      // sees it the cycle after rvalid.
      if (load) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            valid_d  = 1'b1;
            ins_d    = fifo_head.ins;
            dir_d    = fifo_head.addr;
         end else if (rsp_take) begin
            valid_d  = 1'b1;
            ins_d    = imem.imem_rdata;
            dir_d    = resp_pc_q;
         end else begin
            valid_d  = 1'b0;
            ins_d    = NOP_INSN;
            dir_d    = 32'h0;
         end
      end
      fifo_push = rsp_take && !(load && fifo_empty);

      // Redirect overrides everything, including stall; every word still in
      // flight (even one granted or returned this cycle) becomes a drop.
      if (branch_taken) begin
         state_d    = FLUSH;
         pc_d       = branch_target;
         resp_pc_d  = branch_target;
         fifo_clear = 1'b1;
         fifo_push  = 1'b0;
         fifo_pop   = 1'b0;
         valid_d    = 1'b0;
         ins_d      = NOP_INSN;
         dir_d      = 32'h0;
         outst_d    = '0;
         drop_d     = drop_q + outst_q + CNT_W'(granted) - CNT_W'(rsp_any);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         drop_q    <= '0;
         valid_q   <= 1'b0;
         ins_q     <= NOP_INSN;
         dir_q     <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
         valid_q   <= valid_d;
         ins_q     <= ins_d;
         dir_q     <= dir_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_bubbles_q, perf_bubbles_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + 32'(valid_q && !stall);
      perf_bubbles_d = perf_bubbles_q + 32'(!valid_q && !stall);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage: an in-order memory model plus
// an address-sequence reference for requests and delivered instructions.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam logic [31:0] K       = 32'hA5A5_A5A5;
   localparam logic [31:0] STEP    = 32'd4;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } mreq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_if mif ();
   fetch_if wif ();

   logic        stall, br, vld, w_vld;
   logic [31:0] br_tgt, insi, diri, w_insi, w_diri;
`ifdef FETCH_PERF_EN
   logic [31:0] pf, pb, w_pf, w_pb;
`endif

   fetch_stage #(.RESET_PC(32'h0), .PC_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (mif),
      .stall         (stall),
      .branch_taken  (br),
      .branch_target (br_tgt),
      .insi          (insi),
      .diri          (diri),
      .valid         (vld)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (pf),
      .perf_bubbles  (pb)
`endif
   );

   fetch_stage #(.RESET_PC(WRAP_PC), .PC_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .imem          (wif),
      .stall         (1'b0),
      .branch_taken  (1'b0),
      .branch_target (32'h0),
      .insi          (w_insi),
      .diri          (w_diri),
      .valid         (w_vld)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (w_pf),
      .perf_bubbles  (w_pb)
`endif
   );

   int          checks = 0, errors = 0, cyc_n = 0, delivered = 0;
   int          p_gnt, p_resp, p_stall, p_branch;
   bit          force_stall, force_branch;
   logic [31:0] force_tgt;
   logic [31:0] exp_del, exp_req;
   bit          prev_branch, prev_valid, prev_stall, prev_req, prev_gnt;
   logic [31:0] prev_ins, prev_dir, prev_addr;
   mreq_t       mem_q[$];
   bit          w_pend;
   logic [31:0] w_paddr;
   int          w_cnt = 0;
   logic [31:0] w_dirs [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      if (!vld) begin
         chk("bubble_ins", insi, NOP_INSN);
         chk("bubble_dir", diri, 32'h0);
      end else begin
         chk("order_dir", diri, exp_del);
         chk("insn_data", insi, diri ^ K);
      end
      if (prev_branch) begin
         chk("flush_valid", 32'(vld), 32'd0);
         chk("withdraw_req", 32'(mif.imem_req), 32'd0);
      end else if (prev_valid && prev_stall) begin
         chk("hold_valid", 32'(vld), 32'd1);
         chk("hold_ins", insi, prev_ins);
         chk("hold_dir", diri, prev_dir);
      end
      if (prev_req && !prev_gnt && !prev_branch) begin
         chk("req_hold", 32'(mif.imem_req), 32'd1);
         chk("addr_hold", mif.imem_addr, prev_addr);
      end
      if (mif.imem_req) chk("req_addr", mif.imem_addr, exp_req);
      chk("credit_bound", 32'(((exp_req - exp_del) / STEP) <= 32'(DEPTH) + 32'(vld)), 32'd1);
      if (w_vld) begin
         chk("wrap_insn", w_insi, w_diri ^ K);
         if (w_cnt < 3) begin
            w_dirs[w_cnt] = w_diri;
            w_cnt++;
         end
      end
   endtask

   task automatic drive_inputs();
      mif.imem_gnt = (int'($urandom_range(99)) < p_gnt);
      if (mem_q.size() > 0 && mem_q[0].cyc < cyc_n && int'($urandom_range(99)) < p_resp) begin
         mif.imem_rvalid = 1'b1;
         mif.imem_rdata  = mem_q[0].addr ^ K;
      end else begin
         mif.imem_rvalid = 1'b0;
         mif.imem_rdata  = $urandom;
      end
      stall = force_stall || (int'($urandom_range(99)) < p_stall);
      br    = force_branch || (int'($urandom_range(99)) < p_branch);
      if (force_branch)                br_tgt = force_tgt;
      else if ($urandom_range(7) == 0) br_tgt = 32'hFFFF_FFF0;
      else                             br_tgt = $urandom & 32'hFFFF_FFFC;
      wif.imem_gnt    = 1'b1;
      wif.imem_rvalid = w_pend;
      wif.imem_rdata  = w_paddr ^ K;
      w_pend  = wif.imem_req;
      w_paddr = wif.imem_addr;
   endtask

   task automatic update_model();
      if (mif.imem_req && mif.imem_gnt) begin
         mem_q.push_back('{addr: mif.imem_addr, cyc: cyc_n});
         exp_req += STEP;
      end
      if (mif.imem_rvalid) void'(mem_q.pop_front());
      if (br) begin
         exp_req = br_tgt;
         exp_del = br_tgt;
      end else if (vld && !stall) begin
         exp_del += STEP;
         delivered++;
      end
      prev_branch = br;
      prev_valid  = vld;
      prev_stall  = stall;
      prev_req    = mif.imem_req;
      prev_gnt    = mif.imem_gnt;
      prev_ins    = insi;
      prev_dir    = diri;
      prev_addr   = mif.imem_addr;
      cyc_n++;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      drive_inputs();
      update_model();
   endtask

   task automatic do_reset(input bit stale);
      rst = 1'b1;
      mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = 32'h0;
      wif.imem_gnt = 1'b0; wif.imem_rvalid = 1'b0; wif.imem_rdata = 32'h0;
      stall = 1'b0; br = 1'b0; br_tgt = 32'h0;
      mem_q.delete();
      w_pend = 1'b0; w_paddr = 32'h0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_req", 32'(mif.imem_req), 32'd0);
         chk("rst_addr", mif.imem_addr, 32'h0);
         chk("rst_valid", 32'(vld), 32'd0);
         chk("rst_insi", insi, 32'h0);
         chk("rst_diri", diri, 32'h0);
         chk("rst_wrap_addr", wif.imem_addr, WRAP_PC);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_del = 32'h0; exp_req = 32'h0;
      prev_branch = 0; prev_valid = 0; prev_stall = 0; prev_req = 0; prev_gnt = 0;
      mif.imem_gnt = 1'b1;
      if (stale) begin
         mif.imem_rvalid = 1'b1;
         mif.imem_rdata  = 32'hDEAD_BEEF;
      end
      cyc_n++;
   endtask

   task automatic wait_valid(input string nm, input logic [31:0] exp_dir);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         cycle();
         got = vld;
      end
      chk({nm, "_seen"}, 32'(got), 32'd1);
      if (got) chk({nm, "_dir"}, diri, exp_dir);
   endtask

   logic [31:0] a0;

   initial begin
      p_gnt = 100; p_resp = 100; p_stall = 0; p_branch = 0;
      force_stall = 0; force_branch = 0; force_tgt = 32'h0;
      do_reset(1'b0);

      // Zero-wait memory: first instruction three edges after release, then one per cycle.
      cycle(); cycle();
      chk("t1_no_valid_yet", 32'(vld), 32'd0);
      cycle();
      chk("t1_first_valid", 32'(vld), 32'd1);
      chk("t1_dir0", diri, 32'h0);
      chk("t1_ins0", insi, 32'hA5A5_A5A5);
      cycle(); chk("t1_dir4", diri, 32'h4);
      cycle(); chk("t1_dir8", diri, 32'h8);
      repeat (6) cycle();
      chk("t6_wrap_cnt", 32'(w_cnt), 32'd3);
      chk("t6_wrap0", w_dirs[0], 32'hFFFF_FFF8);
      chk("t6_wrap1", w_dirs[1], 32'hFFFF_FFFC);
      chk("t6_wrap2", w_dirs[2], 32'h0000_0000);

      // Stall held five cycles mid-stream.
      force_stall = 1; repeat (5) cycle(); force_stall = 0;
      repeat (8) cycle();

      // Build three outstanding requests, then redirect.
      p_resp = 0;
      for (int i = 0; i < 20 && mem_q.size() != 3; i++) cycle();
      chk("t3_three_outstanding", 32'(mem_q.size()), 32'd3);
      p_gnt = 0; force_branch = 1; force_tgt = 32'h0000_0100;
      cycle();
      force_branch = 0; p_gnt = 100; p_resp = 100;
      wait_valid("t3_target", 32'h0000_0100);
      repeat (6) cycle();

      // Grant withheld four cycles.
      p_gnt = 0;
      cycle(); a0 = mif.imem_addr;
      repeat (3) cycle();
      chk("t4_addr_stable", mif.imem_addr, a0);
      chk("t4_bubble_valid", 32'(vld), 32'd0);
      chk("t4_bubble_ins", insi, 32'h0);
      p_gnt = 100;
      repeat (10) cycle();

      // Branch while stalled with a response returning in the same cycle.
      force_stall = 1; repeat (3) cycle();
      force_branch = 1; force_tgt = 32'h0000_0200;
      cycle();
      force_branch = 0; force_stall = 0;
      wait_valid("t5_target", 32'h0000_0200);
      repeat (4) cycle();

      // Redirect near the top of the address space and run through the wrap.
      force_branch = 1; force_tgt = 32'hFFFF_FFF8;
      cycle();
      force_branch = 0;
      wait_valid("t6_br_wrap", 32'hFFFF_FFF8);
      cycle(); chk("t6_br_wrap1", diri, 32'hFFFF_FFFC);
      cycle(); chk("t6_br_wrap2", diri, 32'h0000_0000);

      // Randomized traffic.
      delivered = 0;
      p_gnt = 70; p_resp = 60; p_stall = 25; p_branch = 3;
      repeat (2000) cycle();
      chk("rand_progress", 32'(delivered > 100), 32'd1);

      // Asynchronous reset mid-burst, then a stray response after release.
      p_gnt = 100; p_resp = 100; p_stall = 0; p_branch = 0;
      for (int i = 0; i < 40 && !vld; i++) cycle();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 32'(vld), 32'd0);
      chk("async_insi", insi, 32'h0);
      chk("async_diri", diri, 32'h0);
      chk("async_req", 32'(mif.imem_req), 32'd0);
      chk("async_addr", mif.imem_addr, 32'h0);
      do_reset(1'b1);
      wait_valid("stale_restart", 32'h0);
      chk("stale_ins", insi, K);
      repeat (20) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
